// File: rtl/led_fade_pwm_pkg.sv
// Shared constants and helpers for the LED fade/PWM stage.
package led_fade_pwm_pkg;

  localparam int          PWM_BITS   = 8;
  localparam logic [7:0]  BRIGHT_MAX = 8'd255;
  localparam int          CLK_HZ     = 50_000_000;
  localparam int          N_LEDS_DEF = 16;

  // 5 ms decay tick and ~48.8 kHz PWM frame at the board clock
  localparam int DECAY_TICK_HZ  = 200;
  localparam int PWM_FRAME_HZ   = 48_828;
  localparam int DECAY_DIV_DEF  = CLK_HZ / DECAY_TICK_HZ;
  localparam int PWM_DIV_DEF    = CLK_HZ / ((1 << PWM_BITS) * PWM_FRAME_HZ);
  localparam int DECAY_STEP_DEF = 16;

  // Brightness scaled by the master dimmer; level+1 lets 255*255 reach 255.
  function automatic logic [7:0] scale_level(input logic [7:0] bright,
                                             input logic [7:0] level);
    logic [15:0] prod;
    prod = 16'(bright) * (16'(level) + 16'd1);
    return prod[15:8];
  endfunction

  // Subtract that clamps at zero instead of wrapping.
  function automatic logic [7:0] sat_sub(input logic [7:0] a,
                                         input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern/dimmer inputs and PWM outputs of the LED fade stage.
interface led_fade_pwm_if #(
  parameter int N_LEDS = 16
);
  logic [N_LEDS-1:0] pattern_in;
  logic              pattern_stb;
  logic              fade_en;
  logic [7:0]        global_level;
  logic [N_LEDS-1:0] led_out;
  logic              frame_start;

  modport master (
    output pattern_in, pattern_stb, fade_en, global_level,
    input  led_out, frame_start
  );

  modport slave (
    input  pattern_in, pattern_stb, fade_en, global_level,
    output led_out, frame_start
  );
endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED: brightness with afterglow decay, dimmer scaling, frame shadow, PWM compare.
module led_pwm_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pat_in_bit,
  input  logic       pat_q_bit,
  input  logic       stb,
  input  logic       tick,
  input  logic       fade_en,
  input  logic [7:0] level,
  input  logic [7:0] pwm_cnt,
  input  logic       boundary,
  output logic       led
);

  localparam logic [7:0] STEP = 8'(DECAY_STEP);

  logic [7:0] bright_q, bright_d;
  logic [7:0] shadow_q, shadow_d;
  logic       led_q, led_d;

  // Next brightness: a strobe wins over a decay tick arriving the same cycle.
  always_comb begin
    bright_d = bright_q;
    if (stb) begin
      if (pat_in_bit)    bright_d = BRIGHT_MAX;
      else if (!fade_en) bright_d = 8'd0;
    end else if (tick && !pat_q_bit) begin
      bright_d = fade_en ? sat_sub(bright_q, STEP) : 8'd0;
    end
  end

  // Shadow only moves at the frame boundary so a frame never changes duty mid-way.
  always_comb begin
    shadow_d = boundary ? scale_level(bright_q, level) : shadow_q;
    led_d    = (shadow_q == BRIGHT_MAX) || (pwm_cnt < shadow_q);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// Top: pattern latch, decay/PWM prescalers, frame counter and per-LED channels.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int N_LEDS     = N_LEDS_DEF,
  parameter int PWM_DIV    = PWM_DIV_DEF,
  parameter int DECAY_DIV  = DECAY_DIV_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  led_fade_pwm_if.slave  bus
);

  localparam int PCW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [PCW-1:0]      pcnt_q, pcnt_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  logic                frame_start_q, frame_start_d;
  logic                tick, pwm_step, boundary;
  logic [N_LEDS-1:0]   led_vec;

  // Prescaler wraps, frame boundary and next values of the shared counters.
  always_comb begin
    tick          = (dcnt_q == DCW'(DECAY_DIV - 1));
    pwm_step      = (pcnt_q == PCW'(PWM_DIV - 1));
    boundary      = pwm_step && (pwm_cnt_q == 8'hFF);
    dcnt_d        = tick ? '0 : dcnt_q + 1'b1;
    pcnt_d        = pwm_step ? '0 : pcnt_q + 1'b1;
    pwm_cnt_d     = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    pat_d         = bus.pattern_stb ? bus.pattern_in : pat_q;
    frame_start_d = boundary;
  end

  // Shared counter and latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q        <= '0;
      dcnt_q        <= '0;
      pwm_cnt_q     <= '0;
      pat_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      dcnt_q        <= dcnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pat_q         <= pat_d;
      frame_start_q <= frame_start_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pat_in_bit (bus.pattern_in[i]),
      .pat_q_bit  (pat_q[i]),
      .stb        (bus.pattern_stb),
      .tick       (tick),
      .fade_en    (bus.fade_en),
      .level      (bus.global_level),
      .pwm_cnt    (pwm_cnt_q),
      .boundary   (boundary),
      .led        (led_vec[i])
    );
  end

  assign bus.led_out     = led_vec;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized bench with a frame-level reference model of the fade/PWM stage.
module tb_led_fade_pwm;

  localparam int NL    = 16;
  localparam int PDIV  = 1;
  localparam int DDIV  = 4;
  localparam int DSTEP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_fade_pwm_if #(.N_LEDS(NL)) bus ();

  led_fade_pwm #(
    .N_LEDS    (NL),
    .PWM_DIV   (PDIV),
    .DECAY_DIV (DDIV),
    .DECAY_STEP(DSTEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: edge index since reset release, plus per-LED levels
  int          e;
  int          m_bright[NL];
  int          m_shadow[NL];
  logic [NL-1:0] m_pat;
  logic [NL-1:0] exp_led;
  logic          exp_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0;
    m_pat = '0;
    exp_led = '0;
    exp_fs = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_bright[i] = 0;
      m_shadow[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int phase;
    phase = e % 256;
    for (int i = 0; i < NL; i++)
      exp_led[i] = (m_shadow[i] == 255) || (phase < m_shadow[i]);
    exp_fs = (phase == 255);
    if (phase == 255)
      for (int i = 0; i < NL; i++)
        m_shadow[i] = (m_bright[i] * (int'(bus.global_level) + 1)) / 256;
    for (int i = 0; i < NL; i++) begin
      if (bus.pattern_stb) begin
        if (bus.pattern_in[i]) m_bright[i] = 255;
        else if (!bus.fade_en) m_bright[i] = 0;
      end else if ((e % DDIV) == DDIV - 1 && !m_pat[i]) begin
        if (!bus.fade_en) m_bright[i] = 0;
        else m_bright[i] = (m_bright[i] > DSTEP) ? m_bright[i] - DSTEP : 0;
      end
    end
    if (bus.pattern_stb) m_pat = bus.pattern_in;
    e++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("led_out", 32'(bus.led_out), 32'(exp_led));
    check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
  endtask

  task automatic strobe(input logic [NL-1:0] pat);
    bus.pattern_in  = pat;
    bus.pattern_stb = 1'b1;
    cycle();
    bus.pattern_stb = 1'b0;
  endtask

  // Run until the next edge to be taken has the given frame phase.
  task automatic run_to_phase(input int p);
    while ((e % 256) != p) cycle();
  endtask

  // Count cycles with led_out[ch] high across the frame that starts now.
  task automatic count_frame(input int ch, output int cnt);
    run_to_phase(255);
    cycle();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      cnt += int'(bus.led_out[ch]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt;
    bus.pattern_in   = '0;
    bus.pattern_stb  = 1'b0;
    bus.fade_en      = 1'b0;
    bus.global_level = 8'd255;
    model_reset();
    #1;
    check("reset_led", 32'(bus.led_out), 32'h0);
    check("reset_fs", 32'(bus.frame_start), 32'h0);
    do_reset();

    // basic lighting: full-on channel 0 for the whole frame
    strobe(16'h0001);
    count_frame(0, cnt);
    check("basic_on_count", 32'(cnt), 32'd256);

    // dimmer: 255 scaled by 127 gives 127 high steps
    bus.global_level = 8'd127;
    count_frame(0, cnt);
    check("dimmer_count", 32'(cnt), 32'd127);
    bus.global_level = 8'd0;
    count_frame(0, cnt);
    check("dimmer_zero", 32'(cnt), 32'd0);

    // decay: release at phase 240, three ticks before the boundary -> 63
    bus.global_level = 8'd255;
    bus.fade_en = 1'b1;
    run_to_phase(240);
    strobe(16'h0000);
    count_frame(0, cnt);
    check("decay_count", 32'(cnt), 32'd63);
    count_frame(0, cnt);
    check("decay_floor", 32'(cnt), 32'd0);

    // strobe/tick collision right before the boundary: cleared bits keep 255
    strobe(16'h00FF);
    run_to_phase(251);
    strobe(16'h000F);
    count_frame(5, cnt);
    check("collision_hold", 32'(cnt), 32'd256);

    // reset mid-frame while fully lit
    bus.fade_en = 1'b0;
    strobe(16'hFFFF);
    run_to_phase(255);
    repeat (11) cycle();
    check("all_lit", 32'(bus.led_out), 32'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_led", 32'(bus.led_out), 32'h0);
    check("midframe_rst_fs", 32'(bus.frame_start), 32'h0);
    do_reset();
    repeat (600) cycle();

    // abrupt off
    strobe(16'hFFFF);
    run_to_phase(200);
    strobe(16'h0000);
    count_frame(3, cnt);
    check("abrupt_off", 32'(cnt), 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) bus.fade_en = ~bus.fade_en;
      if ($urandom_range(0, 127) == 0) bus.global_level = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.pattern_in  = NL'($urandom);
        bus.pattern_stb = 1'b1;
      end else begin
        bus.pattern_stb = 1'b0;
      end
      cycle();
    end
    bus.pattern_stb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
Downstream stage of the dance-light pattern generator. Consumes 16-bit on/off LED patterns, one strobe per pattern. Converts each bit into a per-LED 8-bit brightness that decays when the bit clears, which gives trailing "afterglow" effects. Drives the board LEDs with frame-synchronous PWM, scaled by a global dimmer.

Parameters:
N_LEDS, 16, number of LED channels
PWM_DIV, 4, clk cycles per PWM counter step (frame = 256*PWM_DIV cycles, about 48.8 kHz at 50 MHz)
DECAY_DIV, 250_000, clk cycles between decay ticks (5 ms at 50 MHz)
DECAY_STEP, 16, brightness decrement per decay tick (1..255)

Ports:
clk  input  1  PL clock, 50 MHz
rst  input  1  reset, asynchronous, active-high
pattern_in  input  N_LEDS  on/off pattern from the generator
pattern_stb  input  1  one-cycle load strobe for pattern_in
fade_en  input  1  1 = cleared LEDs decay; 0 = cleared LEDs go dark at once
global_level  input  8  master dimmer, 0 = dark, 255 = full
led_out  output  N_LEDS  registered PWM outputs, active-high
frame_start  output  1  one-cycle pulse at each PWM frame boundary

Behaviour:
- Reset (async, immediate):
  - all counters, pattern latch, brightness, shadow registers, led_out and frame_start go to 0.
  - Reset asserted mid-frame blanks led_out in the same instant.
  - On release, the first frame starts with pwm_cnt = 0.
- Pattern latch:
  - On a clk edge with pattern_stb = 1, pat_q <= pattern_in.
  - For each i with pattern_in[i] = 1: bright[i] <= 255 on that same edge.
  - For each i with pattern_in[i] = 0: bright[i] <= 0 if fade_en = 0; otherwise bright[i] is unchanged.
- Decay:
  - Prescaler dcnt counts 0..DECAY_DIV-1 and wraps; tick = (dcnt == DECAY_DIV-1).
  - On a tick, for each i with pat_q[i] = 0: bright[i] <= bright[i] - DECAY_STEP, saturating at 0 (never wraps).
  - Channels with pat_q[i] = 1 hold 255.
  - If fade_en = 0, the tick forces cleared channels to 0.
- Simultaneous strobe and tick: the strobe has priority. The decay step is skipped for all channels that cycle. dcnt still wraps normally.
- Scaling:
  - eff[i] = (bright[i] * (global_level + 1)) >> 8, computed as 16 bits then truncated to 8.
  - Examples: 255 and 255 give 255; 255 and 127 give 127; any value with level 0 gives 0.
- PWM:
  - Step prescaler pcnt counts 0..PWM_DIV-1.
  - pwm_cnt (8 bits) increments on each pcnt wrap; 255 -> 0 is the frame boundary.
  - At the boundary, shadow[i] <= eff[i] for all i, in the same cycle, and frame_start pulses high for exactly 1 cycle.
  - led_out[i] is registered: 1 if shadow[i] == 255, else (pwm_cnt < shadow[i]).
  - Result: 0 is always off, 255 is always on, and value k is high for k of 256 steps.
- Latency:
  - A pattern or level change never alters led_out mid-frame; it is glitch-free.
  - The change appears on led_out one cycle after the next frame_start.
  - Worst case is 256*PWM_DIV + 1 cycles.
- pattern_stb held high for several cycles: relatches every cycle; lit channels stay at 255; no error.

Decomposition:
- Shared package: PWM_BITS = 8, BRIGHT_MAX = 8'd255, clock-frequency constant CLK_HZ = 50_000_000 (used to derive DECAY_DIV and PWM_DIV), and N_LEDS default.
- One sub-module, led_pwm_channel, per LED via generate. It holds:
  - the per-channel inputs: pattern bit, strobe, tick, fade_en, global_level, pwm_cnt, frame boundary;
  - bright, the saturating decay, the scaling, shadow, and the comparator.
- Top level owns dcnt, pcnt, pwm_cnt, pat_q and frame_start.

Test Plan:
All scenarios use sim parameters PWM_DIV = 1, DECAY_DIV = 4, DECAY_STEP = 64.
- Basic lighting: reset, global_level = 255, fade_en = 0, strobe 16'h0001 -> after the next frame_start, led_out = 16'h0001 held constant for the whole frame.
- Decay, no wrap:
  - Setup: fade_en = 1, strobe 16'h0001, then after 1 frame strobe 16'h0000.
  - Expected bright[0]: 255 -> 191 -> 127 -> 63 -> 0 on successive ticks, then stays 0.
  - Expected led_out[0] high-count per frame: tracks the shadowed value (e.g. 191 of 256).
- Dimmer: bright = 255, global_level = 127 -> eff = 127; led_out[0] high for exactly 127 of 256 cycles per frame, cycles 0..126.
- Strobe/tick collision: pattern_stb coincident with tick = 1 -> lit bits go to 255; cleared bits keep their value, no decay applied that cycle.
- Reset mid-frame: assert rst while led_out = 16'hFFFF -> led_out = 0 immediately, frame_start = 0; after release, all channels stay dark until a new strobe.
- Abrupt off: fade_en = 0, strobe 16'hFFFF, then 16'h0000 -> all bright = 0 on the strobe edge; led_out = 0 from one cycle after the next frame_start.
